apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB initiator that turns a simple valid/ready request channel into single APB3 transfers.
//  It drives the peripheral side of the SoC's APB slaves (GPIO controller and others) and
//  returns read data and error status on a valid/ready response channel.
//  One transfer is in flight at a time. A watchdog ends any transfer whose slave never
//  asserts PREADY.
// PARAMETERS
//  ADDR_W          32   width of req_addr / PADDR
//  DATA_W          32   width of write/read data
//  TIMEOUT_CYCLES  256  maximum ACCESS-phase cycles before forced error; 0 = watchdog disabled
// PORTS
//  PCLK        in   1       bus clock, all logic on rising edge
//  PRESET      in   1       asynchronous reset, active-high
//  req_valid   in   1       request present
//  req_ready   out  1       bridge can accept request
//  req_write   in   1       1 = write, 0 = read
//  req_addr    in   ADDR_W  target address
//  req_wdata   in   DATA_W  write data
//  rsp_valid   out  1       response present
//  rsp_ready   in   1       response consumed
//  rsp_rdata   out  DATA_W  read data (0 for writes and timeouts)
//  rsp_err     out  1       PSLVERR seen or watchdog timeout
//  rsp_timeout out  1       error was caused by the watchdog
//  PSEL        out  1       APB select
//  PENABLE     out  1       APB enable
//  PWRITE      out  1       APB direction
//  PADDR       out  ADDR_W  APB address
//  PWDATA      out  DATA_W  APB write data
//  PRDATA      in   DATA_W  APB read data
//  PREADY      in   1       APB ready
//  PSLVERR     in   1       APB slave error
// BEHAVIOUR
//  Reset (async, PRESET=1)
//   - state=IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_err and rsp_timeout are 0.
//   - PADDR, PWDATA and rsp_rdata are 0; timeout counter is 0; req_ready is 1 after reset.
//   - Reset during any phase aborts the transfer with no response. PSEL/PENABLE drop immediately.
//  FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All outputs are registered except req_ready.
//   - IDLE: req_ready=1 (combinational: state==IDLE).
//       On req_valid&&req_ready, latch write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
//   - SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
//   - ACCESS: PSEL=1, PENABLE=1. PADDR, PWRITE and PWDATA are held stable from SETUP to ACCESS exit.
//       PREADY=1 -> capture response, drop PSEL/PENABLE next cycle, go to RESP:
//         rsp_rdata = PWRITE ? 0 : PRDATA;  rsp_err = PSLVERR;  rsp_timeout = 0.
//       PREADY=0 -> counter++. When counter == TIMEOUT_CYCLES-1 and PREADY is still 0:
//         go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//       PREADY=1 on the timeout cycle wins: it is a normal completion.
//   - RESP: rsp_valid=1. Response fields stay stable until rsp_ready=1, then go to IDLE.
//       Counter clears on leaving RESP.
//  Latency: request accepted at edge N -> PSEL at N+1 -> PENABLE at N+2.
//   With zero wait states, rsp_valid=1 at N+3. Minimum issue interval is 4 cycles.
//  req_valid while busy is ignored (req_ready=0); the requester holds the request.
//  PSLVERR is sampled only when PREADY=1 in ACCESS.
//  The counter is DATA-independent, width $clog2(TIMEOUT_CYCLES+1), and saturates.
//   TIMEOUT_CYCLES=0 -> wait in ACCESS indefinitely.
//  No PSEL without a preceding SETUP cycle; PENABLE is never high while PSEL is low.
// TESTING
//  Zero-wait write, addr 0x04, data 0x0000_00FF, slave PREADY=1:
//   -> PSEL at N+1, PENABLE at N+2, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
//  Read addr 0x00 with 3 wait states, PRDATA=0xA5A5_0F0F:
//   -> PADDR stable through 4 ACCESS cycles; rsp_rdata=0xA5A5_0F0F at N+6.
//  Write addr 0x30 with slave PSLVERR=1 on completion:
//   -> rsp_err=1, rsp_timeout=0, bus idle next cycle.
//  TIMEOUT_CYCLES=4, PREADY held 0:
//   -> exit after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, PSEL=0.
//  Hold rsp_ready=0 for 5 cycles, req_valid=1 throughout:
//   -> rsp stable, req_ready=0, no new SETUP until rsp handshake.
//  Assert PRESET during ACCESS:
//   -> PSEL=PENABLE=0 same cycle, no rsp_valid. After release, the next request runs normally.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Request/response channel plus APB3 bus for apb_master_bridge.
// master = bridge view, slave = requester/peripheral environment.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr,
    input  req_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE,
    output PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr,
    output req_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE,
    input  PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator fed by a valid/ready request
// channel, with a response channel and an ACCESS-phase watchdog.
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic           PCLK,
  input logic           PRESET,
  apb_master_bridge_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W =
    WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LAST_I =
    WD_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  assign bus.req_ready = (state == IDLE);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.PSEL        <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PWRITE      <= 1'b0;
      bus.PADDR       <= {ADDR_W{1'b0}};
      bus.PWDATA      <= {DATA_W{1'b0}};
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= {DATA_W{1'b0}};
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.PWRITE <= bus.req_write;
            bus.PADDR  <= bus.req_addr;
            bus.PWDATA <= bus.req_wdata;
            bus.PSEL   <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          // PREADY on the last watchdog cycle still completes normally
          if (bus.PREADY) begin
            bus.PSEL        <= 1'b0;
            bus.PENABLE     <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_rdata   <= bus.PWRITE ?
                               {DATA_W{1'b0}} : bus.PRDATA;
            bus.rsp_err     <= bus.PSLVERR;
            bus.rsp_timeout <= 1'b0;
            state           <= RESP;
          end else if (WD_EN && cnt == CNT_LAST) begin
            bus.PSEL        <= 1'b0;
            bus.PENABLE     <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_rdata   <= {DATA_W{1'b0}};
            bus.rsp_err     <= 1'b1;
            bus.rsp_timeout <= 1'b1;
            state           <= RESP;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            cnt           <= '0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge with a transaction-level
// reference model and a cycle-driven APB slave.
module tb_apb_master_bridge;

  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_bridge #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .PCLK(clk),
    .PRESET(rst),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Transaction-level expectation: response content and the number
  // of cycles from the accept cycle to the first rsp_valid cycle.
  task automatic ref_rsp(input bit wr, input int w,
                         input logic [31:0] prd,
                         input bit serr,
                         output logic [31:0] rd,
                         output bit err, output bit to,
                         output int lat);
    if (w >= T) begin
      rd = 32'h0; err = 1'b1; to = 1'b1; lat = 2 + T;
    end else begin
      rd = wr ? 32'h0 : prd;
      err = serr; to = 1'b0; lat = 3 + w;
    end
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input int w,
                      input logic [31:0] prd, input bit serr,
                      input int hold);
    logic [31:0] e_rd;
    bit e_err, e_to;
    int lat;
    ref_rsp(wr, w, prd, serr, e_rd, e_err, e_to, lat);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    cyc();
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    chk("setup_psel", 32'(bus.PSEL), 32'd1);
    chk("setup_penable", 32'(bus.PENABLE), 32'd0);
    chk("setup_paddr", bus.PADDR, addr);
    chk("setup_pwrite", 32'(bus.PWRITE), 32'(wr));
    chk("setup_req_ready", 32'(bus.req_ready), 32'd0);
    for (int k = 0; k < lat - 2; k++) begin
      cyc();
      chk("acc_sel_en", {30'd0, bus.PSEL, bus.PENABLE},
          32'd3);
      chk("acc_paddr", bus.PADDR, addr);
      chk("acc_pwdata", bus.PWDATA, wd);
      chk("acc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      bus.PREADY  = (k == w);
      bus.PRDATA  = (k == w) ? prd : $urandom;
      bus.PSLVERR = (k == w) ? serr : 1'($urandom);
    end
    cyc();
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_bus_idle", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
    chk("rsp_rdata", bus.rsp_rdata, e_rd);
    chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
    chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e_to));
    for (int h = 0; h < hold; h++) begin
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      cyc();
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, e_rd);
      chk("hold_err", {30'd0, bus.rsp_err, bus.rsp_timeout},
          {30'd0, e_err, e_to});
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      chk("hold_psel", 32'(bus.PSEL), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("done_req_ready", 32'(bus.req_ready), 32'd1);
    chk("done_psel", 32'(bus.PSEL), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_sel_en", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
    chk("rst_pwrite", 32'(bus.PWRITE), 32'd0);
    chk("rst_paddr", bus.PADDR, 32'd0);
    chk("rst_pwdata", bus.PWDATA, 32'd0);
    chk("rst_rsp", {29'd0, bus.rsp_valid, bus.rsp_err,
        bus.rsp_timeout}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    rst = 1'b0;
    cyc();

    xfer(1'b1, 32'h04, 32'h0000_00FF, 0, 32'h1234_5678, 1'b0, 0);
    xfer(1'b0, 32'h00, 32'h0, 3, 32'hA5A5_0F0F, 1'b0, 0);
    xfer(1'b1, 32'h30, 32'hDEAD_BEEF, 1, 32'h0, 1'b1, 0);
    xfer(1'b0, 32'h08, 32'h0, 9, 32'hFFFF_FFFF, 1'b0, 0);
    xfer(1'b0, 32'h0C, 32'h0, T, 32'h5555_AAAA, 1'b0, 1);
    xfer(1'b0, 32'h10, 32'h0, 2, 32'h0BAD_F00D, 1'b1, 5);

    // reset while the slave is stalling in ACCESS
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h44;
    cyc();
    bus.req_valid = 1'b0;
    cyc();
    chk("pre_rst_penable", 32'(bus.PENABLE), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_sel_en", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("arst_req_ready", 32'(bus.req_ready), 32'd1);
    cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("post_rst_psel", 32'(bus.PSEL), 32'd0);
    xfer(1'b0, 32'h48, 32'h0, 1, 32'hC0FF_EE00, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      xfer(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom,
           int'($urandom_range(T + 2, 0)), $urandom,
           1'($urandom), int'($urandom_range(3, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
